// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
);
    logic                     loading;
    logic                     req0;
    logic                     req1;
    logic                     we0;
    logic                     we1;
    logic [ADDRESS_WIDTH-1:0] addr0;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0]    wdata0;
    logic [DATA_WIDTH-1:0]    wdata1;
    logic                     gnt0;
    logic                     gnt1;
    logic                     rvalid0;
    logic                     rvalid1;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     mem_cen;
    logic                     mem_wen;
    logic                     mem_oen;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_datain;
    logic [DATA_WIDTH-1:0]    mem_dataout;

    modport slave (
        input  loading, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_cen, mem_wen, mem_oen, mem_addr, mem_datain
    );

    modport master (
        output loading, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_cen, mem_wen, mem_oen, mem_addr, mem_datain
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for one single-port RAM with burst limiting
// Optional: ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed P0 priority.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST     = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic gnt0, gnt1, forced;
    logic has_owner, owner_is1, own_req, oth_req, at_limit;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        forced    = 1'b0;
        has_owner = (owner_q != OWN_NONE);
        owner_is1 = (owner_q == OWN_P1);
        own_req   = owner_is1 ? bus.req1 : bus.req0;
        oth_req   = owner_is1 ? bus.req0 : bus.req1;
        at_limit  = (cnt_q == LAST_CNT);
        if (!rst && !bus.loading) begin
            if (has_owner && own_req && (cnt_q < LAST_CNT)) begin
                gnt0 = ~owner_is1;
                gnt1 = owner_is1;
            end else if (has_owner && at_limit && oth_req) begin
                gnt0   = owner_is1;
                gnt1   = ~owner_is1;
                forced = 1'b1;
            end else if (bus.req0 && !bus.req1) begin
                gnt0 = 1'b1;
            end else if (bus.req1 && !bus.req0) begin
                gnt1 = 1'b1;
            end else if (bus.req0 && bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                gnt0 = last_q;
                gnt1 = ~last_q;
`else
                gnt0 = 1'b1;
`endif
            end
        end
    end

    // A forced switch is a single access; ownership is released so the tie-break
    // rule picks who starts the next burst.
    always_comb begin
        owner_d   = OWN_NONE;
        cnt_d     = '0;
        last_d    = last_q;
        rvalid0_d = gnt0 & ~bus.we0;
        rvalid1_d = gnt1 & ~bus.we1;
        if (gnt0 || gnt1) begin
            last_d = gnt1;
            if (forced) begin
                owner_d = OWN_NONE;
            end else if (has_owner && (gnt1 == owner_is1)) begin
                owner_d = owner_q;
                cnt_d   = at_limit ? '0 : cnt_q + 1'b1;
            end else begin
                owner_d = gnt1 ? OWN_P1 : OWN_P0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.rdata      = bus.mem_dataout;
    assign bus.mem_cen    = ~(gnt0 | gnt1);
    assign bus.mem_wen    = ~((gnt0 & bus.we0) | (gnt1 & bus.we1));
    assign bus.mem_oen    = rst;
    assign bus.mem_addr   = gnt0 ? bus.addr0  : (gnt1 ? bus.addr1  : '0);
    assign bus.mem_datain = gnt0 ? bus.wdata0 : (gnt1 ? bus.wdata1 : '0);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: one-cycle read latency, external loader port used while loading
    logic [DW-1:0] ram [0:2**AW-1];
    logic          ld_we   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_we) ram[ld_addr] <= ld_data;
        else if (!bus.mem_cen && !bus.mem_wen) ram[bus.mem_addr] <= bus.mem_datain;
        if (!bus.mem_cen && bus.mem_wen) bus.mem_dataout <= ram[bus.mem_addr];
    end

    // reference model: holder of the current burst and how many grants it has had
    int            m_holder = -1;
    int            m_run    = 0;
    bit            m_last   = 1'b1;
    bit            exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] shadow [0:2**AW-1];
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic int model_grant(bit r0, bit r1);
        bit own, oth;
        if (rst || bus.loading) return -1;
        if (m_holder >= 0) begin
            own = (m_holder == 1) ? r1 : r0;
            oth = (m_holder == 1) ? r0 : r1;
            if (own && m_run < MB) return m_holder;
            if (oth && m_run == MB) return 1 - m_holder;
        end
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        return -1;
    endfunction

    function automatic logic [1:0] enc(int g);
        return (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
    endfunction

    task automatic model_commit(int g);
        exp_rv0 = (g == 0) && !bus.we0;
        exp_rv1 = (g == 1) && !bus.we1;
        if (g == 0) begin
            if (bus.we0) shadow[bus.addr0] = bus.wdata0;
            else exp_rd = shadow[bus.addr0];
        end else if (g == 1) begin
            if (bus.we1) shadow[bus.addr1] = bus.wdata1;
            else exp_rd = shadow[bus.addr1];
        end
        if (rst) begin
            m_holder = -1; m_run = 0; m_last = 1'b1; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        end else if (g < 0) begin
            m_holder = -1; m_run = 0;
        end else begin
            if (m_holder >= 0 && g != m_holder && m_run == MB) begin
                m_holder = -1; m_run = 0;
            end else if (g == m_holder) begin
                m_run = (m_run == MB) ? 1 : m_run + 1;
            end else begin
                m_holder = g; m_run = 1;
            end
            m_last = (g == 1);
        end
    endtask

    task automatic set_port(int p, bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        else begin bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    endtask

    task automatic idle(int n);
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        repeat (n) begin
            @(posedge clk); model_commit(model_grant(0, 0)); #1;
        end
    endtask

    task automatic test_reset();
        set_port(0, 1, 0, 11'h123, 32'hA5A5A5A5);
        set_port(1, 1, 1, 11'h321, 32'h5A5A5A5A);
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen, bus.mem_oen} !== 5'b00111) begin
            n_err++; $display("FAIL reset_ctl: got %b want 00111",
                {bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen, bus.mem_oen});
        end
        n_cmp++;
        if (bus.mem_addr !== '0 || bus.mem_datain !== '0) begin
            n_err++; $display("FAIL reset_bus: got addr %h data %h want 0 0", bus.mem_addr, bus.mem_datain);
        end
        @(posedge clk); model_commit(-1); #1;
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin
            n_err++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0});
        end
        rst = 1'b0;
        idle(1);
        n_cmp++;
        if (bus.mem_oen !== 1'b0) begin
            n_err++; $display("FAIL oen_run: got %b want 0", bus.mem_oen);
        end
    endtask

    task automatic preload();
        bus.loading = 1'b1;
        ld_we = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ld_addr = AW'(a);
            ld_data = (a == 16) ? 32'hDEADBEEF : DW'($urandom);
            shadow[a] = ld_data;
            @(posedge clk); model_commit(-1); #1;
        end
        ld_we = 1'b0;
        bus.loading = 1'b0;
    endtask

    task automatic test_read();
        idle(1);
        set_port(0, 1, 0, 11'h010, '0);
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen} !== 4'b0101 || bus.mem_addr !== 11'h010) begin
            n_err++; $display("FAIL read_grant: got gnt/cen/wen %b addr %h want 0101 010",
                {bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen}, bus.mem_addr);
        end
        @(posedge clk); model_commit(0); #1;
        set_port(0, 0, 0, '0, '0);
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b01 || bus.rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL read_data: got rv %b rdata %h want 01 deadbeef",
                {bus.rvalid1, bus.rvalid0}, bus.rdata);
        end
    endtask

    task automatic test_write_read_wrap();
        idle(1);
        set_port(1, 1, 1, 11'h7FF, 32'h12345678);
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0, bus.mem_wen} !== 3'b100 || bus.mem_addr !== 11'h7FF
            || bus.mem_datain !== 32'h12345678) begin
            n_err++; $display("FAIL wr_grant: got gnt/wen %b addr %h data %h want 100 7ff 12345678",
                {bus.gnt1, bus.gnt0, bus.mem_wen}, bus.mem_addr, bus.mem_datain);
        end
        @(posedge clk); model_commit(1); #1;
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin
            n_err++; $display("FAIL wr_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0});
        end
        set_port(1, 1, 0, 11'h7FF, '0);
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0, bus.mem_wen} !== 3'b101) begin
            n_err++; $display("FAIL rd_grant: got %b want 101", {bus.gnt1, bus.gnt0, bus.mem_wen});
        end
        @(posedge clk); model_commit(1); #1;
        set_port(1, 0, 0, '0, '0);
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b10 || bus.rdata !== 32'h12345678) begin
            n_err++; $display("FAIL wrap_data: got rv %b rdata %h want 10 12345678",
                {bus.rvalid1, bus.rvalid0}, bus.rdata);
        end
    endtask

    task automatic test_burst_limit();
        logic [1:0] pat1 [12];
        logic [1:0] pat2 [7];
        int g;
        pat1 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        pat2 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        idle(2);
        for (int i = 0; i < 12; i++) begin
            set_port(0, 1, 0, AW'($urandom_range(0, 31)), '0);
            set_port(1, 1, 0, AW'($urandom_range(0, 31)), '0);
            #3; g = model_grant(1, 1);
            n_cmp++;
            if ({bus.gnt1, bus.gnt0} !== pat1[i]) begin
                n_err++; $display("FAIL burst_pat cyc %0d: got %b want %b", i, {bus.gnt1, bus.gnt0}, pat1[i]);
            end
            @(posedge clk); model_commit(g); #1;
        end
        idle(2);
        for (int i = 0; i < 7; i++) begin
            set_port(0, (i != 2), 0, AW'($urandom_range(0, 31)), '0);
            set_port(1, 1, 0, AW'($urandom_range(0, 31)), '0);
            #3; g = model_grant(bus.req0, 1);
            n_cmp++;
            if ({bus.gnt1, bus.gnt0} !== pat2[i]) begin
                n_err++; $display("FAIL switch_pat cyc %0d: got %b want %b", i, {bus.gnt1, bus.gnt0}, pat2[i]);
            end
            @(posedge clk); model_commit(g); #1;
        end
        idle(1);
    endtask

    task automatic test_loading();
        int g;
        idle(1);
        set_port(0, 1, 0, 11'h010, '0);
        #3; g = model_grant(1, 0);
        @(posedge clk); model_commit(g); #1;
        bus.loading = 1'b1;
        set_port(0, 1, 0, 11'h005, '0);
        set_port(1, 1, 0, 11'h006, '0);
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b01 || bus.rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL load_inflight: got rv %b rdata %h want 01 deadbeef",
                {bus.rvalid1, bus.rvalid0}, bus.rdata);
        end
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if ({bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen} !== 4'b0011) begin
                n_err++; $display("FAIL load_block cyc %0d: got %b want 0011", i,
                    {bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen});
            end
            @(posedge clk); model_commit(-1); #1;
            n_cmp++;
            if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin
                n_err++; $display("FAIL load_rvalid cyc %0d: got %b want 00", i, {bus.rvalid1, bus.rvalid0});
            end
        end
        bus.loading = 1'b0;
        #3; g = model_grant(1, 1);
        n_cmp++;
        if ({bus.gnt1, bus.gnt0} !== enc(g) || bus.mem_cen !== 1'b0) begin
            n_err++; $display("FAIL load_resume: got gnt %b cen %b want %b 0",
                {bus.gnt1, bus.gnt0}, bus.mem_cen, enc(g));
        end
        @(posedge clk); model_commit(g); #1;
        idle(1);
    endtask

    task automatic test_reset_inflight();
        idle(1);
        set_port(0, 1, 0, 11'h003, '0);
        #3;
        @(posedge clk); model_commit(model_grant(1, 0)); #1;
        rst = 1'b1;
        set_port(0, 1, 0, 11'h004, '0);
        set_port(1, 1, 0, 11'h006, '0);
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen, bus.mem_oen, bus.rvalid0} !== 6'b001111) begin
            n_err++; $display("FAIL rst_mid: got gnt/cen/wen/oen/rv0 %b want 001111",
                {bus.gnt1, bus.gnt0, bus.mem_cen, bus.mem_wen, bus.mem_oen, bus.rvalid0});
        end
        @(posedge clk); model_commit(-1); #1;
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin
            n_err++; $display("FAIL rst_mid_rv: got %b want 00", {bus.rvalid1, bus.rvalid0});
        end
        rst = 1'b0;
        #3;
        n_cmp++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            n_err++; $display("FAIL rst_first_gnt: got %b want 01", {bus.gnt1, bus.gnt0});
        end
        @(posedge clk); model_commit(0); #1;
        idle(2);
    endtask

    task automatic test_random();
        int g;
        bit p0, p1;
        logic [AW-1:0] ea;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 1) == 1)
                begin p0 = 1; set_port(0, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom)); end
            else if (p0 && $urandom_range(0, 19) == 0) p0 = 0;
            if (!p1 && $urandom_range(0, 1) == 1)
                begin p1 = 1; set_port(1, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom)); end
            else if (p1 && $urandom_range(0, 19) == 0) p1 = 0;
            bus.req0 = p0;
            bus.req1 = p1;
            bus.loading = ($urandom_range(0, 15) == 0);
            #3; g = model_grant(p0, p1);
            ea = (g == 0) ? bus.addr0 : ((g == 1) ? bus.addr1 : '0);
            n_cmp++;
            if ({bus.gnt1, bus.gnt0} !== enc(g) || bus.mem_cen !== (g < 0)
                || bus.mem_wen !== !((g == 0 && bus.we0) || (g == 1 && bus.we1)) || bus.mem_addr !== ea) begin
                n_err++; $display("FAIL rand_gnt cyc %0d: got gnt %b cen %b wen %b addr %h want gnt %b addr %h",
                    i, {bus.gnt1, bus.gnt0}, bus.mem_cen, bus.mem_wen, bus.mem_addr, enc(g), ea);
            end
            @(posedge clk); model_commit(g); #1;
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
            n_cmp++;
            if ({bus.rvalid1, bus.rvalid0} !== {exp_rv1, exp_rv0}
                || ((exp_rv0 || exp_rv1) && bus.rdata !== exp_rd)) begin
                n_err++; $display("FAIL rand_rd cyc %0d: got rv %b rdata %h want rv %b rdata %h",
                    i, {bus.rvalid1, bus.rvalid0}, bus.rdata, {exp_rv1, exp_rv0}, exp_rd);
            end
        end
        bus.loading = 1'b0;
        idle(1);
    endtask

    initial begin
        bus.loading = 1'b0;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        @(posedge clk); #1;
        test_reset();
        preload();
        test_read();
        test_write_read_wrap();
        test_burst_limit();
        test_loading();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
